i2s_tx_serializer: RTL

//  Downstream stage of the cascaded biquad filter: takes the filter's held 16-bit signed output
//  and sends it as a standard Philips I2S stream to the audio DAC.

---
 rtl/i2s_tx_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: sends the held 16-bit filter output as a mono Philips I2S stream.
// BCLK and LRCK are divided down from clk. One sample is captured per frame and sent
// MSB-first in both the left and the right slot.
// Optional build macro: I2S_TX_MUTE_EN adds a frame-aligned mute input.
//
// Handshake: none in the valid/ready sense. sample_req is a one-clk strobe that is high
// in the cycle after the clk edge that captured din. The upstream chain may use it to
// time its own update. din must simply be stable across that capture edge.
module i2s_tx_serializer #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] din,
`ifdef I2S_TX_MUTE_EN
  input  logic               mute,
`endif
  output logic               sample_req,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_sdata,
  output logic               state_dbg
);

  localparam int DATA_W     = 16;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int DCW        = $clog2(CLK_DIV);

  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic        [DCW-1:0]     div_cnt_q, div_cnt_d;
  logic        [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic signed [DATA_W-1:0]  hold_q, hold_d;
  logic                      bclk_q, bclk_d;
  logic                      lrck_q, lrck_d;
  logic                      sdata_q, sdata_d;
  logic                      req_q, req_d;

  // Scratch values for a fall event: the advanced bit position and its offset in the slot.
  logic        [CW-1:0]      bit_nxt;
  logic        [CW-1:0]      slot_pos;

  // Next-state logic: divider, BCLK toggle, per-fall bit advance, and the frame-start capture.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    bit_nxt   = bit_cnt_q;
    slot_pos  = '0;

    if (div_cnt_q == DCW'(CLK_DIV - 1)) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        // Fall event: everything the DAC samples on the next rising BCLK changes here.
        bit_nxt   = (bit_cnt_q == CW'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + CW'(1);
        bit_cnt_d = bit_nxt;
        lrck_d    = (bit_nxt >= CW'(SLOT_BITS));
        slot_pos  = lrck_d ? (bit_nxt - CW'(SLOT_BITS)) : bit_nxt;

        // Position 0 is the one-BCLK I2S delay bit. It is always padding, so the sample
        // never carries across a slot boundary.
        if ((state_q == ST_RUN) && (slot_pos >= CW'(1)) && (slot_pos <= CW'(DATA_W)))
          sdata_d = hold_q[4'(CW'(DATA_W) - slot_pos)];
        else
          sdata_d = 1'b0;

        if (bit_nxt == '0) begin
`ifdef I2S_TX_MUTE_EN
          hold_d = mute ? '0 : din;
`else
          hold_d = din;
`endif
          req_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
    end else begin
      div_cnt_d = div_cnt_q + DCW'(1);
    end
  end

  // State registers. Reset aborts any frame in progress and starts from the last bit of
  // a silent frame, so the first fall event after reset is a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      div_cnt_q <= '0;
      bit_cnt_q <= CW'(FRAME_BITS - 1);
      hold_q    <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
    end
  end

  assign sample_req = req_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign state_dbg  = (state_q == ST_RUN);

endmodule
